load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU. Takes the ALU result as the effective address for LOAD/STORE and
//  performs one data-memory transaction per instruction over a req/ack bus. Handles byte/half/word lane steering
//  and load sign/zero extension, then hands a registered writeback packet to the register file.
//  Non-memory ops pass their ALU result through with one cycle of latency. Stalls upstream while a transaction is open.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles waiting for mem_ack before aborting with bus_err (1..255)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  in_valid     in   1   instruction from ALU stage is valid this cycle
//  in_ready     out  1   stage can accept; in_valid&&in_ready = accept
//  opcode       in   7   RV32I opcode (LOAD 0000011, STORE 0100011, other = pass-through)
//  funct3       in   3   access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  rd           in   5   destination register
//  alu_result   in   32  effective address (mem ops) or result (others)
//  store_data   in   32  rs2 value for stores
//  mem_req      out  1   bus request, held until mem_ack
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word address {addr[31:2],2'b00}
//  mem_wdata    out  32  store data replicated to the addressed lanes
//  mem_wstrb    out  4   byte enables (0000 for loads)
//  mem_rdata    in   32  read data, valid with mem_ack
//  mem_ack      in   1   transaction complete, one-cycle pulse
//  wb_valid     out  1   writeback packet valid, one-cycle pulse
//  wb_we        out  1   register write enable (0 for stores, rd==0, faults)
//  wb_rd        out  5   destination register
//  wb_data      out  32  writeback value
//  misalign     out  1   pulse with wb_valid: misaligned access, no bus transaction
//  bus_err      out  1   pulse with wb_valid: ack timeout, transaction aborted
// BEHAVIOUR
//  Reset: state IDLE; mem_req, mem_we, wb_valid, wb_we, misalign, bus_err = 0; mem_addr, mem_wdata, wb_data = 0;
//   mem_wstrb = 0; wb_rd = 0; timeout counter = 0. Async reset mid-transaction drops mem_req immediately.
//  FSM IDLE -> BUS -> IDLE. in_ready = (state==IDLE).
//  IDLE, accept of non-mem op: next cycle wb_valid=1, wb_data=alu_result, wb_we=(rd!=0). Latency 1.
//  IDLE, accept of aligned mem op: latch all fields; next cycle mem_req=1 -> BUS. Misaligned = h/hu with addr[0]=1,
//   or w with addr[1:0]!=0. Misaligned or illegal funct3 -> no request; next cycle wb_valid=1, misalign=1, wb_we=0.
//  BUS: mem_req and all mem_* held stable. Timeout counter increments each BUS cycle without ack.
//   mem_ack -> mem_req=0, wb_valid=1 the next cycle, return to IDLE. Earliest load latency: accept+1 req, ack same
//   cycle as req, wb_valid at accept+2.
//   Counter reaches TIMEOUT_CYCLES without ack -> drop req, wb_valid=1, bus_err=1, wb_we=0, return to IDLE.
//  mem_ack outside BUS is ignored. A new accept is not possible in the cycle wb_valid is high after BUS
//   (in_ready rises that same cycle, so accept takes effect next edge).
//  Store lanes: sb wstrb=0001<<a[1:0], wdata={4{d[7:0]}}; sh wstrb=0011<<a[1:0], wdata={2{d[15:0]}}; sw wstrb=1111.
//  Load extract: byte = rdata>>(8*a[1:0]), half = rdata>>(8*a[1:0]); lb/lh sign-extend, lbu/lhu zero-extend.
//  Stores: wb_valid=1, wb_we=0, wb_data=0.
// STRUCTURE
//  Shared package rv_pkg: opcode localparams (LOAD, STORE, ...), funct3 size codes, FSM state encoding.
//  Sub-module lsu_align: combinational store lane steering, misalign detect and load extend; FSM stays at top.
// TESTING
//  lw rd=5 addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> mem_addr 0x100, wstrb 0000, wb_data 0xDEADBEEF, wb_we=1.
//  lb addr 0x103, rdata 0x80FFFFFF -> wb_data 0xFFFFFF80; lbu same -> 0x00000080.
//  sh addr 0x202, data 0x1234ABCD -> mem_addr 0x200, wstrb 1100, wdata 0xABCDABCD, wb_we=0.
//  lw addr 0x102 -> no mem_req, misalign=1 with wb_valid, wb_we=0; ADD pass-through rd=0 -> wb_we=0, latency 1.
//  no ack for 16 cycles -> bus_err=1, mem_req=0, in_ready=1; later stray ack ignored.
//  assert rst while mem_req=1 -> mem_req=0 same cycle, all outputs at reset values, next lw completes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the memory stage: opcodes, access-size codes
// and the load/store FSM state encoding.
package rv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_BUS
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store steering and misalign/illegal-size
// detection for the incoming op, sign/zero extension for the returning load.
module lsu_align
  import rv_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misalign,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // Unsigned sizes are legal only for loads; unknown sizes are treated as faults too.
  always_comb begin
    wstrb    = 4'b0000;
    wdata    = store_data;
    misalign = 1'b0;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        wstrb    = 4'b0011 << addr_lo;
        wdata    = {2{store_data[15:0]}};
        misalign = addr_lo[0];
      end
      F3_W: begin
        wstrb    = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      F3_BU:   misalign = is_store;
      F3_HU:   misalign = is_store | addr_lo[0];
      default: misalign = 1'b1;
    endcase
    if (!is_store) begin
      wstrb = 4'b0000;
    end
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data = rdata;
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage after the ALU: one req/ack bus transaction per load/store,
// pass-through for everything else, registered writeback packet.
module load_store_unit
  import rv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  logic [7:0]  wait_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        store_q;

  logic        is_store;
  logic        align_bad;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] ld_data;

  assign is_store = (opcode == OP_STORE);
  assign in_ready = (state == ST_IDLE);

  lsu_align u_align (
    .is_store   (is_store),
    .funct3     (funct3),
    .addr_lo    (alu_result[1:0]),
    .store_data (store_data),
    .wstrb      (lane_strb),
    .wdata      (lane_wdata),
    .misalign   (align_bad),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .rdata      (mem_rdata),
    .ld_data    (ld_data)
  );

  // Load offset/size are latched at accept so extension uses them when the ack arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'h0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
      store_q   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'h0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem_op(opcode)) begin
              wb_valid <= 1'b1;
              wb_we    <= (rd != 5'd0);
              wb_rd    <= rd;
              wb_data  <= alu_result;
            end else if (align_bad) begin
              wb_valid <= 1'b1;
              misalign <= 1'b1;
              wb_rd    <= rd;
              wb_data  <= 32'h0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {alu_result[31:2], 2'b00};
              mem_wdata <= is_store ? lane_wdata : 32'h0;
              mem_wstrb <= lane_strb;
              f3_q      <= funct3;
              off_q     <= alu_result[1:0];
              rd_q      <= rd;
              store_q   <= is_store;
              wait_cnt  <= 8'h0;
              state     <= ST_BUS;
            end
          end
        end
        ST_BUS: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_we    <= !store_q && (rd_q != 5'd0);
            wb_data  <= store_q ? 32'h0 : ld_data;
            wait_cnt <= 8'h0;
            state    <= ST_IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            wb_valid <= 1'b1;
            bus_err  <= 1'b1;
            wb_rd    <= rd_q;
            wait_cnt <= 8'h0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'h1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected writeback
// packets, pushed when an instruction is driven and popped when wb_valid fires.
module tb_load_store_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = 7'h0;
  logic [2:0]  funct3 = 3'h0;
  logic [4:0]  rd = 5'h0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic        bus_err;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        berr;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .rd(rd), .alu_result(alu_result),
    .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic we, input logic [4:0] r, input logic [31:0] d,
                          input logic chk, input logic mis, input logic berr);
    wb_exp_t e;
    e.we = we; e.rd = r; e.data = d; e.chk_data = chk; e.mis = mis; e.berr = berr;
    sb_q.push_back(e);
  endtask

  // Present one instruction at the negedge; returns #1 after the accepting edge.
  task automatic issue(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] r, input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_in_ready got=%b want=1", name, in_ready);
    end
    in_valid = 1'b1; opcode = op; funct3 = f3; rd = r; alu_result = a; store_data = sd;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(input string name, input int budget);
    int n = 0;
    wb_exp_t e;
    while (wb_valid !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (wb_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_wb_timeout got wb_valid=%b want=1", name, wb_valid);
      if (sb_q.size() > 0) e = sb_q.pop_front();
    end else if (sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s_wb_unexpected got wb_valid=1 want no packet", name);
    end else begin
      e = sb_q.pop_front();
      if (wb_we !== e.we || wb_rd !== e.rd || misalign !== e.mis || bus_err !== e.berr ||
          (e.chk_data && wb_data !== e.data)) begin
        failures++;
        $display("[TB] FAIL %s_wb got we=%b rd=%0d data=%h mis=%b berr=%b want we=%b rd=%0d data=%h mis=%b berr=%b",
                 name, wb_we, wb_rd, wb_data, misalign, bus_err, e.we, e.rd, e.data, e.mis, e.berr);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_wb_pulse got wb_valid=%b want=0", name, wb_valid);
    end
  endtask

  task automatic run_load(input string name, input logic [2:0] f3, input logic [4:0] r,
                          input logic [31:0] a, input logic [31:0] rdata, input int delay,
                          input logic [31:0] exp_data);
    logic [31:0] exp_addr;
    exp_addr = a & 32'hFFFF_FFFC;
    issue(name, OP_LOAD, f3, r, a, 32'h0);
    push_exp(r != 5'd0, r, exp_data, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr || mem_wstrb !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL %s_req got req=%b we=%b addr=%h strb=%b want req=1 we=0 addr=%h strb=0000",
               name, mem_req, mem_we, mem_addr, mem_wstrb, exp_addr);
    end
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr || wb_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s_hold got req=%b addr=%h wb_valid=%b want req=1 addr=%h wb_valid=0",
                 name, mem_req, mem_addr, wb_valid, exp_addr);
      end
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_req_drop got req=%b want=0", name, mem_req);
    end
    wait_wb(name, 0);
  endtask

  task automatic run_store(input string name, input logic [2:0] f3, input logic [4:0] r,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    logic [31:0] exp_addr;
    exp_addr = a & 32'hFFFF_FFFC;
    issue(name, OP_STORE, f3, r, a, d);
    push_exp(1'b0, r, 32'h0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr ||
        mem_wstrb !== exp_strb || mem_wdata !== exp_wdata) begin
      failures++;
      $display("[TB] FAIL %s_req got req=%b we=%b addr=%h strb=%b wdata=%h want req=1 we=1 addr=%h strb=%b wdata=%h",
               name, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, exp_addr, exp_strb, exp_wdata);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    wait_wb(name, 0);
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({mem_req, mem_we, wb_valid, wb_we, misalign, bus_err, mem_addr, mem_wdata,
         mem_wstrb, wb_rd, wb_data} !== 111'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s got req=%b we=%b wbv=%b wbwe=%b mis=%b berr=%b addr=%h wdata=%h strb=%b rd=%0d data=%h rdy=%b want all 0 rdy=1",
               name, mem_req, mem_we, wb_valid, wb_we, misalign, bus_err, mem_addr, mem_wdata,
               mem_wstrb, wb_rd, wb_data, in_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    run_load("lw_0x100", F3_W, 5'd5, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
  endtask

  // Zero ack delay also exercises the minimum accept-to-writeback latency of two cycles.
  task automatic test_load_extend();
    run_load("lb_0x103",  F3_B,  5'd6, 32'h0000_0103, 32'h80FF_FFFF, 0, 32'hFFFF_FF80);
    run_load("lbu_0x103", F3_BU, 5'd6, 32'h0000_0103, 32'h80FF_FFFF, 0, 32'h0000_0080);
    run_load("lb_0x101",  F3_B,  5'd7, 32'h0000_0101, 32'h8001_7F00, 0, 32'h0000_007F);
    run_load("lh_0x102",  F3_H,  5'd8, 32'h0000_0102, 32'h8001_7F00, 1, 32'hFFFF_8001);
    run_load("lhu_0x102", F3_HU, 5'd8, 32'h0000_0102, 32'h8001_7F00, 0, 32'h0000_8001);
    run_load("lh_0x100",  F3_H,  5'd0, 32'h0000_0100, 32'h8001_7F00, 0, 32'h0000_7F00);
  endtask

  task automatic test_store();
    logic [3:0] sb_strb [4];
    sb_strb[0] = 4'b0001; sb_strb[1] = 4'b0010; sb_strb[2] = 4'b0100; sb_strb[3] = 4'b1000;
    run_store("sh_0x202", F3_H, 5'd3, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
    run_store("sh_0x200", F3_H, 5'd3, 32'h0000_0200, 32'h1234_ABCD, 4'b0011, 32'hABCD_ABCD);
    run_store("sw_0x300", F3_W, 5'd4, 32'h0000_0300, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      run_store("sb_lane", F3_B, 5'd2, 32'h0000_0400 + 32'(i), 32'h7777_775A, sb_strb[i], 32'h5A5A_5A5A);
    end
  endtask

  task automatic run_fault(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [4:0] r, input logic [31:0] a);
    issue(name, op, f3, r, a, 32'h1111_2222);
    push_exp(1'b0, r, 32'h0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_no_req got req=%b want=0", name, mem_req);
    end
    wait_wb(name, 0);
  endtask

  task automatic test_misalign();
    run_fault("lw_0x102",  OP_LOAD,  F3_W,  5'd9,  32'h0000_0102);
    run_fault("lhu_0x101", OP_LOAD,  F3_HU, 5'd9,  32'h0000_0101);
    run_fault("sh_0x203",  OP_STORE, F3_H,  5'd9,  32'h0000_0203);
    run_fault("sbu_ill",   OP_STORE, F3_BU, 5'd9,  32'h0000_0200);
    run_fault("ld_f3_011", OP_LOAD,  3'b011, 5'd9, 32'h0000_0200);
  endtask

  task automatic test_passthrough();
    issue("add_rd0", OP_REG, 3'b000, 5'd0, 32'h0000_1234, 32'h0);
    push_exp(1'b0, 5'd0, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    wait_wb("add_rd0", 0);
    issue("addi_rd7", OP_IMM, 3'b000, 5'd7, 32'h8765_4321, 32'h0);
    push_exp(1'b1, 5'd7, 32'h8765_4321, 1'b1, 1'b0, 1'b0);
    wait_wb("addi_rd7", 0);
  endtask

  // Consecutive pass-through ops: one accept per cycle, one packet per cycle.
  task automatic test_back_to_back();
    wb_exp_t e;
    @(negedge clk);
    in_valid = 1'b1; opcode = OP_REG; rd = 5'd10; alu_result = 32'hAAAA_0001;
    push_exp(1'b1, 5'd10, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      checks++;
      if (wb_valid !== 1'b1 || wb_we !== e.we || wb_rd !== e.rd || wb_data !== e.data || in_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL b2b_%0d got v=%b we=%b rd=%0d data=%h rdy=%b want v=1 we=%b rd=%0d data=%h rdy=1",
                 i, wb_valid, wb_we, wb_rd, wb_data, in_ready, e.we, e.rd, e.data);
      end
      if (i < 2) begin
        rd = 5'(11 + i); alu_result = 32'hAAAA_0002 + 32'(i);
        push_exp(1'b1, rd, alu_result, 1'b1, 1'b0, 1'b0);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_end got wb_valid=%b want=0", wb_valid);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    issue("lw_timeout", OP_LOAD, F3_W, 5'd12, 32'h0000_0500, 32'h0);
    push_exp(1'b0, 5'd12, 32'h0, 1'b0, 1'b0, 1'b1);
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 16 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_len got req_cycles=%0d rdy=%b want req_cycles=16 rdy=1", n, in_ready);
    end
    wait_wb("lw_timeout", 0);
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stray_ack got wbv=%b req=%b rdy=%b want wbv=0 req=0 rdy=1", wb_valid, mem_req, in_ready);
    end
  endtask

  task automatic test_reset_mid_bus();
    issue("lw_rst", OP_LOAD, F3_W, 5'd13, 32'h0000_0600, 32'h0);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_pre_req got req=%b want=1", mem_req);
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid_bus");
    @(negedge clk);
    rst = 1'b0;
    run_load("lw_after_rst", F3_W, 5'd14, 32'h0000_0700, 32'h0BAD_F00D, 2, 32'h0BAD_F00D);
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_misalign();
    test_passthrough();
    test_back_to_back();
    test_timeout();
    test_reset_mid_bus();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got left=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
